multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Multicycle successor to the single-cycle opcode decoder: a Moore FSM that sequences each MIPS instruction over 3–5 cycles.
- Sits between the instruction register (opcode/funct fields) and the shared-memory, single-ALU datapath.
- Adds memory wait-state handshake, JAL/JR/SLTI/XORI support, illegal-opcode trap and a retired-instruction counter.

Parameters:
- MEM_WAIT, default 1, meaning: 1 = memory states hold until mem_ready is high; 0 = mem_ready is ignored and each memory state lasts one cycle.
- CNT_W, default 32, meaning: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- op  in  6  opcode_type, IR[31:26].
- funct  in  6  IR[5:0]; used only to detect JR.
- zero  in  1  ALU zero flag (informational; branch resolution is done by datapath gating).
- mem_ready  in  1  memory completes the current access this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_beq  out  1  PC load if zero.
- pc_write_bne  out  1  PC load if !zero.
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- ir_write  out  1  IR load enable.
- reg_dst  out  2  destination select: 0 = rt, 1 = rd, 2 = $31.
- mem_to_reg  out  2  write-back source: 0 = ALUOut, 1 = MDR, 2 = PC.
- reg_write  out  1  register-file write enable.
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = rs.
- alu_src_b  out  2  ALU B select: 0 = rt, 1 = const 4, 2 = sign-extended imm, 3 = sign-extended imm<<2.
- alu_op  out  3  alu_op_type.
- pc_source  out  2  PC source: 0 = ALU, 1 = ALUOut, 2 = jump target, 3 = rs.
- illegal_op  out  1  one-cycle pulse on an unknown opcode.
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction.
- retired  out  CNT_W  count of completed instructions.

Behaviour:
- Reset (async, rst_n = 0):
  - state goes to FETCH and retired clears to 0.
  - All strobes and enables are 0; muxes are 0; alu_op = ADD.
- Outputs are a function of state only (Moore); all selects not listed for a state are 0.
- FETCH:
  - Asserts mem_read, ir_write, alu_src_b = 1, alu_op = ADD, pc_write.
  - With MEM_WAIT = 1, ir_write and pc_write assert only when mem_ready = 1, and the FSM stays in FETCH until then.
  - Exits to DECODE.
- DECODE:
  - Asserts alu_src_b = 3, alu_op = ADD (branch-target precompute).
  - Next state by opcode:
    - LW or SW: MEM_ADDR.
    - RTYPE with funct = JR (001000): JR_EX.
    - RTYPE otherwise: EXEC_R.
    - ADDI, SLTI or XORI: EXEC_I.
    - BEQ or BNE: BRANCH.
    - J: JUMP.
    - JAL: JAL_WB.
    - Any other opcode: TRAP.
- MEM_ADDR: alu_src_a = 1, alu_src_b = 2, ADD. Goes to MEM_RD for LW, MEM_WR for SW.
- MEM_RD: i_or_d = 1, mem_read; waits on mem_ready as in FETCH. Goes to MEM_WB.
- MEM_WB: reg_dst = 0, mem_to_reg = 1, reg_write, instr_done. Goes to FETCH.
- MEM_WR: i_or_d = 1, mem_write held until mem_ready, then instr_done. Goes to FETCH.
- EXEC_R: alu_src_a = 1, alu_src_b = 0, alu_op = FUNCT. Goes to ALU_WB with reg_dst = 1.
- EXEC_I: alu_src_a = 1, alu_src_b = 2, alu_op chosen by opcode: ADDI = ADD, SLTI = SLT, XORI = XOR. Goes to ALU_WB with reg_dst = 0.
  - XORI needs zero-extension; the datapath selects it by opcode, not this block.
- ALU_WB: mem_to_reg = 0, reg_write, instr_done. reg_dst is held from the previous state in a registered flag. Goes to FETCH.
- BRANCH: alu_src_a = 1, alu_src_b = 0, alu_op = SUB, pc_source = 1; pc_write_beq for BEQ or pc_write_bne for BNE; instr_done. Goes to FETCH.
- JUMP: pc_source = 2, pc_write, instr_done. Goes to FETCH.
- JAL_WB: reg_dst = 2, mem_to_reg = 2, reg_write, pc_source = 2, pc_write, instr_done. Goes to FETCH.
  - PC already holds PC+4 at this point.
- JR_EX: pc_source = 3, pc_write, instr_done. Goes to FETCH.
- TRAP: illegal_op = 1 for one cycle, no writes, not counted as retired. Goes to FETCH.
- retired increments by 1 on every cycle where instr_done = 1 and wraps modulo 2^CNT_W.
- Reset asserted mid-instruction aborts it immediately; no partial write strobe may remain high after rst_n falls.
- MEM_WAIT = 1 with mem_ready stuck low: the FSM stays in its memory state indefinitely with the strobe held; no timeout.

Decomposition:
- Shared types package holds:
  - opcode_type, extended with SLTI 001010, XORI 001110, JAL 000011;
  - FUNCT_JR constant;
  - alu_op_type: ADD = 000, SUB = 001, FUNCT = 010, SLT = 011, XOR = 100;
  - mux-select enums for reg_dst, mem_to_reg, alu_src_b, pc_source.
- ctrl_state_t enum is local to the module.
- No sub-module: next-state logic, output decode and counter live in one file.

Test Plan:
- LW, MEM_WAIT = 1, mem_ready low for 2 cycles in both FETCH and MEM_RD -> 9 cycles FETCH..MEM_WB; reg_write for exactly 1 cycle with mem_to_reg = 1; retired 0→1.
- R-type ADD then SW with mem_ready tied high -> 4 + 4 cycles; mem_write for 1 cycle with i_or_d = 1; retired = 2.
- BEQ then BNE -> pc_write_beq then pc_write_bne, each in BRANCH, each with alu_op = 001 and pc_source = 1.
- JAL -> JAL_WB shows reg_dst = 2, mem_to_reg = 2, reg_write = 1, pc_write = 1, pc_source = 2; JR (op 0, funct 8) -> pc_source = 3.
- op = 6'b111111 -> illegal_op pulses in TRAP, no write strobes, retired unchanged, FSM back to FETCH.
- Two stimuli:
  - rst_n low during MEM_WR -> mem_write drops in the same cycle and state goes to FETCH.
  - CNT_W = 4 with 17 instructions -> retired = 1 (wraps).

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared types for the multicycle MIPS control unit: opcodes, ALU
// operation codes, datapath mux selects and the registered control word.
package multicycle_control_pkg;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'b000000,
    OP_J     = 6'b000010,
    OP_JAL   = 6'b000011,
    OP_BEQ   = 6'b000100,
    OP_BNE   = 6'b000101,
    OP_ADDI  = 6'b001000,
    OP_SLTI  = 6'b001010,
    OP_XORI  = 6'b001110,
    OP_LW    = 6'b100011,
    OP_SW    = 6'b101011
  } opcode_type;

  localparam logic [5:0] FUNCT_JR = 6'b001000;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'b000,
    ALU_SUB   = 3'b001,
    ALU_FUNCT = 3'b010,
    ALU_SLT   = 3'b011,
    ALU_XOR   = 3'b100
  } alu_op_type;

  typedef enum logic [1:0] {
    RD_RT = 2'd0,
    RD_RD = 2'd1,
    RD_RA = 2'd2
  } reg_dst_t;

  typedef enum logic [1:0] {
    WB_ALUOUT = 2'd0,
    WB_MDR    = 2'd1,
    WB_PC     = 2'd2
  } mem_to_reg_t;

  typedef enum logic [1:0] {
    SRCB_RT      = 2'd0,
    SRCB_FOUR    = 2'd1,
    SRCB_IMM     = 2'd2,
    SRCB_IMM_SH2 = 2'd3
  } alu_src_b_t;

  typedef enum logic [1:0] {
    PCS_ALU    = 2'd0,
    PCS_ALUOUT = 2'd1,
    PCS_JUMP   = 2'd2,
    PCS_RS     = 2'd3
  } pc_source_t;

  // Complete control word held in flops. wait_gate marks states whose
  // completion strobes must additionally wait for mem_ready.
  typedef struct packed {
    logic        pc_write;
    logic        pc_write_beq;
    logic        pc_write_bne;
    logic        i_or_d;
    logic        mem_read;
    logic        mem_write;
    logic        ir_write;
    reg_dst_t    reg_dst;
    mem_to_reg_t mem_to_reg;
    logic        reg_write;
    logic        alu_src_a;
    alu_src_b_t  alu_src_b;
    alu_op_type  alu_op;
    pc_source_t  pc_source;
    logic        illegal_op;
    logic        instr_done;
    logic        wait_gate;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

  // ALU operation for the immediate-arithmetic group.
  function automatic alu_op_type imm_alu_op(input logic [5:0] op);
    alu_op_type res;
    case (op)
      OP_SLTI: res = ALU_SLT;
      OP_XORI: res = ALU_XOR;
      default: res = ALU_ADD;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM. The control word is decoded from the next
// state and registered, so every output follows the state register. Only
// the memory-completion strobes (ir_write/pc_write in FETCH, instr_done in
// MEM_WR) are qualified by mem_ready when MEM_WAIT is set.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter bit MEM_WAIT = 1'b1,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_beq,
  output logic             pc_write_bne,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic [1:0]       reg_dst,
  output logic [1:0]       mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic             illegal_op,
  output logic             instr_done,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALU_WB   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_JAL_WB   = 4'd11,
    S_JR_EX    = 4'd12,
    S_TRAP     = 4'd13
  } ctrl_state_t;

  ctrl_state_t      state_q, state_d;
  ctrl_t            ctrl_q, ctrl_d;
  logic             rtype_wb_q, rtype_wb_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             ready_ok_s;
  logic             gate_pass_s;
  logic             instr_done_s;
  logic             unused_zero_s;

  // Branch outcome is resolved by the datapath from zero; not needed here.
  assign unused_zero_s = zero;

  // Memory handshake qualification for the current state.
  always_comb begin
    ready_ok_s   = (MEM_WAIT == 1'b0) || mem_ready;
    gate_pass_s  = !ctrl_q.wait_gate || ready_ok_s;
    instr_done_s = ctrl_q.instr_done && gate_pass_s;
  end

  // Next-state sequencing. The first cycle after reset has no fetch
  // strobes yet, so FETCH only advances once its read has been issued.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (ctrl_q.mem_read && ready_ok_s) state_d = S_DECODE;
        else                               state_d = S_FETCH;
      end
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_RTYPE: begin
            if (funct == FUNCT_JR) state_d = S_JR_EX;
            else                   state_d = S_EXEC_R;
          end
          OP_ADDI, OP_SLTI, OP_XORI: state_d = S_EXEC_I;
          OP_BEQ, OP_BNE:            state_d = S_BRANCH;
          OP_J:                      state_d = S_JUMP;
          OP_JAL:                    state_d = S_JAL_WB;
          default:                   state_d = S_TRAP;
        endcase
      end
      S_MEM_ADDR: begin
        if (op == OP_SW) state_d = S_MEM_WR;
        else             state_d = S_MEM_RD;
      end
      S_MEM_RD: begin
        if (ready_ok_s) state_d = S_MEM_WB;
        else            state_d = S_MEM_RD;
      end
      S_MEM_WR: begin
        if (ready_ok_s) state_d = S_FETCH;
        else            state_d = S_MEM_WR;
      end
      S_EXEC_R, S_EXEC_I: state_d = S_ALU_WB;
      default:            state_d = S_FETCH;
    endcase
  end

  // Remember whether the pending ALU write-back targets rd (R-type) or rt.
  always_comb begin
    if (state_d == S_EXEC_R)      rtype_wb_d = 1'b1;
    else if (state_d == S_EXEC_I) rtype_wb_d = 1'b0;
    else                          rtype_wb_d = rtype_wb_q;
  end

  // Control word for the state being entered.
  always_comb begin
    ctrl_d = CTRL_IDLE;
    case (state_d)
      S_FETCH: begin
        ctrl_d.mem_read  = 1'b1;
        ctrl_d.ir_write  = 1'b1;
        ctrl_d.alu_src_b = SRCB_FOUR;
        ctrl_d.pc_write  = 1'b1;
        ctrl_d.wait_gate = MEM_WAIT;
      end
      S_DECODE: begin
        ctrl_d.alu_src_b = SRCB_IMM_SH2;
      end
      S_MEM_ADDR: begin
        ctrl_d.alu_src_a = 1'b1;
        ctrl_d.alu_src_b = SRCB_IMM;
      end
      S_MEM_RD: begin
        ctrl_d.i_or_d   = 1'b1;
        ctrl_d.mem_read = 1'b1;
      end
      S_MEM_WB: begin
        ctrl_d.reg_dst    = RD_RT;
        ctrl_d.mem_to_reg = WB_MDR;
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.instr_done = 1'b1;
      end
      S_MEM_WR: begin
        ctrl_d.i_or_d     = 1'b1;
        ctrl_d.mem_write  = 1'b1;
        ctrl_d.instr_done = 1'b1;
        ctrl_d.wait_gate  = MEM_WAIT;
      end
      S_EXEC_R: begin
        ctrl_d.alu_src_a = 1'b1;
        ctrl_d.alu_src_b = SRCB_RT;
        ctrl_d.alu_op    = ALU_FUNCT;
      end
      S_EXEC_I: begin
        ctrl_d.alu_src_a = 1'b1;
        ctrl_d.alu_src_b = SRCB_IMM;
        ctrl_d.alu_op    = imm_alu_op(op);
      end
      S_ALU_WB: begin
        if (rtype_wb_q) ctrl_d.reg_dst = RD_RD;
        else            ctrl_d.reg_dst = RD_RT;
        ctrl_d.mem_to_reg = WB_ALUOUT;
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctrl_d.alu_src_a    = 1'b1;
        ctrl_d.alu_src_b    = SRCB_RT;
        ctrl_d.alu_op       = ALU_SUB;
        ctrl_d.pc_source    = PCS_ALUOUT;
        ctrl_d.pc_write_beq = (op == OP_BEQ);
        ctrl_d.pc_write_bne = (op == OP_BNE);
        ctrl_d.instr_done   = 1'b1;
      end
      S_JUMP: begin
        ctrl_d.pc_source  = PCS_JUMP;
        ctrl_d.pc_write   = 1'b1;
        ctrl_d.instr_done = 1'b1;
      end
      S_JAL_WB: begin
        ctrl_d.reg_dst    = RD_RA;
        ctrl_d.mem_to_reg = WB_PC;
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.pc_source  = PCS_JUMP;
        ctrl_d.pc_write   = 1'b1;
        ctrl_d.instr_done = 1'b1;
      end
      S_JR_EX: begin
        ctrl_d.pc_source  = PCS_RS;
        ctrl_d.pc_write   = 1'b1;
        ctrl_d.instr_done = 1'b1;
      end
      S_TRAP: begin
        ctrl_d.illegal_op = 1'b1;
      end
      default: begin
        ctrl_d = CTRL_IDLE;
      end
    endcase
  end

  // Retired-instruction counter, wrapping naturally at 2^CNT_W.
  always_comb begin
    retired_d = retired_q + CNT_W'(instr_done_s);
  end

  // State, control word, write-back flag and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_FETCH;
      ctrl_q     <= CTRL_IDLE;
      rtype_wb_q <= 1'b0;
      retired_q  <= '0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      rtype_wb_q <= rtype_wb_d;
      retired_q  <= retired_d;
    end
  end

  assign pc_write     = ctrl_q.pc_write && gate_pass_s;
  assign pc_write_beq = ctrl_q.pc_write_beq;
  assign pc_write_bne = ctrl_q.pc_write_bne;
  assign i_or_d       = ctrl_q.i_or_d;
  assign mem_read     = ctrl_q.mem_read;
  assign mem_write    = ctrl_q.mem_write;
  assign ir_write     = ctrl_q.ir_write && gate_pass_s;
  assign reg_dst      = ctrl_q.reg_dst;
  assign mem_to_reg   = ctrl_q.mem_to_reg;
  assign reg_write    = ctrl_q.reg_write;
  assign alu_src_a    = ctrl_q.alu_src_a;
  assign alu_src_b    = ctrl_q.alu_src_b;
  assign alu_op       = ctrl_q.alu_op;
  assign pc_source    = ctrl_q.pc_source;
  assign illegal_op   = ctrl_q.illegal_op;
  assign instr_done   = instr_done_s;
  assign retired      = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed and random
// instructions with random memory wait states, checked against a
// per-instruction reference model of lengths, strobe counts and final-cycle
// control values.
module tb_multicycle_control;

  localparam logic [5:0] OP_R    = 6'd0;
  localparam logic [5:0] OP_J    = 6'd2;
  localparam logic [5:0] OP_JAL  = 6'd3;
  localparam logic [5:0] OP_BEQ  = 6'd4;
  localparam logic [5:0] OP_BNE  = 6'd5;
  localparam logic [5:0] OP_ADDI = 6'd8;
  localparam logic [5:0] OP_SLTI = 6'd10;
  localparam logic [5:0] OP_XORI = 6'd14;
  localparam logic [5:0] OP_LW   = 6'd35;
  localparam logic [5:0] OP_SW   = 6'd43;

  localparam int C_LW = 0, C_SW = 1, C_R = 2, C_JR = 3, C_I = 4,
                 C_BR = 5, C_J = 6, C_JAL = 7, C_TRAP = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, zero, mem_ready;
  logic [5:0] op, funct;
  logic pc_write, pc_write_beq, pc_write_bne, i_or_d, mem_read, mem_write, ir_write;
  logic [1:0] reg_dst, mem_to_reg, alu_src_b, pc_source;
  logic reg_write, alu_src_a, illegal_op, instr_done;
  logic [2:0] alu_op;
  logic [31:0] retired;

  logic rst4_n, ready4;
  logic [5:0] op4, funct4;
  logic pcw4, beq4, bne4, iord4, mr4, mw4, irw4, rw4, srca4, ill4, done4;
  logic [1:0] rd4, m2r4, srcb4, pcs4;
  logic [2:0] aluop4;
  logic [3:0] retired4;

  multicycle_control #(.MEM_WAIT(1'b1), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .pc_write_beq(pc_write_beq),
    .pc_write_bne(pc_write_bne), .i_or_d(i_or_d), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
    .illegal_op(illegal_op), .instr_done(instr_done), .retired(retired)
  );

  multicycle_control #(.MEM_WAIT(1'b0), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst4_n), .op(op4), .funct(funct4), .zero(1'b0),
    .mem_ready(ready4), .pc_write(pcw4), .pc_write_beq(beq4),
    .pc_write_bne(bne4), .i_or_d(iord4), .mem_read(mr4),
    .mem_write(mw4), .ir_write(irw4), .reg_dst(rd4),
    .mem_to_reg(m2r4), .reg_write(rw4), .alu_src_a(srca4),
    .alu_src_b(srcb4), .alu_op(aluop4), .pc_source(pcs4),
    .illegal_op(ill4), .instr_done(done4), .retired(retired4)
  );

  int n_vec = 0;
  int n_bad = 0;
  logic [31:0] exp_retired = 32'd0;

  logic [5:0] lop[11] = '{OP_LW, OP_SW, OP_R, OP_R, OP_ADDI, OP_SLTI, OP_XORI,
                          OP_BEQ, OP_BNE, OP_J, OP_JAL};
  logic [5:0] bad_ops[5] = '{6'h3f, 6'h01, 6'h06, 6'h20, 6'h3a};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Instruction class from the opcode/funct rules.
  function automatic int cls(input logic [5:0] o, input logic [5:0] f);
    case (o)
      OP_LW:                     return C_LW;
      OP_SW:                     return C_SW;
      OP_R:                      return (f == 6'b001000) ? C_JR : C_R;
      OP_ADDI, OP_SLTI, OP_XORI: return C_I;
      OP_BEQ, OP_BNE:            return C_BR;
      OP_J:                      return C_J;
      OP_JAL:                    return C_JAL;
      default:                   return C_TRAP;
    endcase
  endfunction

  // Cycles from the first FETCH cycle through the last cycle.
  function automatic int exp_len(input int c, input int wf, input int wm);
    case (c)
      C_LW:      return 5 + wf + wm;
      C_SW:      return 4 + wf + wm;
      C_R, C_I:  return 4 + wf;
      default:   return 3 + wf;
    endcase
  endfunction

  // Expected {reg_dst, mem_to_reg, pc_source, i_or_d, reg_write, pc_write,
  // beq, bne, mem_write, mem_read, ir_write, illegal_op, instr_done}.
  function automatic logic [31:0] exp_fin(input int c, input logic [5:0] o);
    logic [1:0] rd, m2r, pcs;
    logic iod, rw, pcw, bq, bn, mw, ill, dn;
    rd = 2'd0; m2r = 2'd0; pcs = 2'd0;
    iod = 1'b0; rw = 1'b0; pcw = 1'b0; bq = 1'b0; bn = 1'b0; mw = 1'b0;
    ill = 1'b0; dn = 1'b1;
    case (c)
      C_LW:   begin m2r = 2'd1; rw = 1'b1; end
      C_SW:   begin iod = 1'b1; mw = 1'b1; end
      C_R:    begin rd = 2'd1; rw = 1'b1; end
      C_I:    begin rw = 1'b1; end
      C_BR:   begin pcs = 2'd1; bq = (o == OP_BEQ); bn = (o == OP_BNE); end
      C_J:    begin pcs = 2'd2; pcw = 1'b1; end
      C_JAL:  begin rd = 2'd2; m2r = 2'd2; pcs = 2'd2; rw = 1'b1; pcw = 1'b1; end
      C_JR:   begin pcs = 2'd3; pcw = 1'b1; end
      default: begin ill = 1'b1; dn = 1'b0; end
    endcase
    return {16'd0, rd, m2r, pcs, iod, rw, pcw, bq, bn, mw, 1'b0, 1'b0, ill, dn};
  endfunction

  // Expected {alu_src_a, alu_src_b, alu_op} two cycles after FETCH ends.
  function automatic logic [31:0] exp_third(input int c, input logic [5:0] o);
    case (c)
      C_LW, C_SW: return {26'd0, 1'b1, 2'd2, 3'd0};
      C_R:        return {26'd0, 1'b1, 2'd0, 3'd2};
      C_I:        return {26'd0, 1'b1, 2'd2, (o == OP_SLTI) ? 3'd3 : (o == OP_XORI) ? 3'd4 : 3'd0};
      C_BR:       return {26'd0, 1'b1, 2'd0, 3'd1};
      default:    return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] all_outs();
    return {10'd0, pc_write, pc_write_beq, pc_write_bne, i_or_d, mem_read, mem_write,
            ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
            pc_source, illegal_op, instr_done};
  endfunction

  // After reset release, wait (bounded) until FETCH issues its read with
  // mem_ready low; the DUT is then still in FETCH at the next cycle.
  task automatic wait_fetch(input string tag);
    int g;
    mem_ready = 1'b0;
    g = 0;
    @(negedge clk);
    while (!(mem_read && !i_or_d) && g < 6) begin
      @(negedge clk);
      g++;
    end
    check(tag, {31'd0, mem_read && !i_or_d && !mem_write}, 32'd1);
    @(posedge clk); #1;
  endtask

  // Run one instruction starting in FETCH with wf FETCH waits and wm waits
  // in its memory data state, then check it against the model.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int wf, input int wm);
    int c, len, n_mr, n_mw, n_ir, n_pcw, n_rw, n_br;
    logic [31:0] fin, third, dec_b;
    bit fin_seen, memc;
    c = cls(o, f);
    memc = (c == C_LW) || (c == C_SW);
    op = o; funct = f; zero = 1'($urandom_range(0, 1));
    len = 0; n_mr = 0; n_mw = 0; n_ir = 0; n_pcw = 0; n_rw = 0; n_br = 0;
    fin = 32'hffff_ffff; third = 32'hffff_ffff; dec_b = 32'hffff_ffff;
    fin_seen = 1'b0;
    while (!fin_seen && len < 24) begin
      if (len < wf) mem_ready = 1'b0;
      else if (len == wf) mem_ready = 1'b1;
      else if (memc && len >= wf + 3 && len < wf + 3 + wm) mem_ready = 1'b0;
      else if (memc && len == wf + 3 + wm) mem_ready = 1'b1;
      else mem_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      n_mr += int'(mem_read); n_mw += int'(mem_write); n_ir += int'(ir_write);
      n_pcw += int'(pc_write); n_rw += int'(reg_write);
      n_br += int'(pc_write_beq) * 2 + int'(pc_write_bne);
      if (len == wf + 1) dec_b = {30'd0, alu_src_b};
      if (len == wf + 2) third = {26'd0, alu_src_a, alu_src_b, alu_op};
      fin = {16'd0, reg_dst, mem_to_reg, pc_source, i_or_d, reg_write, pc_write,
             pc_write_beq, pc_write_bne, mem_write, mem_read, ir_write, illegal_op, instr_done};
      fin_seen = instr_done || illegal_op;
      len++;
      if (!fin_seen) begin @(posedge clk); #1; end
    end
    @(posedge clk); #1;
    if (c != C_TRAP) exp_retired++;
    check("length", len, exp_len(c, wf, wm));
    check("mem_read_cycles", n_mr, 1 + wf + ((c == C_LW) ? 1 + wm : 0));
    check("mem_write_cycles", n_mw, (c == C_SW) ? 1 + wm : 0);
    check("ir_write_cycles", n_ir, 1);
    check("pc_write_cycles", n_pcw, 1 + ((c == C_J || c == C_JAL || c == C_JR) ? 1 : 0));
    check("reg_write_cycles", n_rw, (c == C_LW || c == C_R || c == C_I || c == C_JAL) ? 1 : 0);
    check("branch_strobes", n_br, (o == OP_BEQ) ? 2 : (o == OP_BNE) ? 1 : 0);
    check("decode_srcb", dec_b, 32'd3);
    check("third_cycle_alu", third, exp_third(c, o));
    check("final_cycle", fin, exp_fin(c, o));
    check("retired", retired, exp_retired);
  endtask

  initial begin
    int k, len;
    logic [5:0] o, f;
    rst_n = 1'b0; rst4_n = 1'b0; zero = 1'b0; mem_ready = 1'b0;
    op = 6'd0; funct = 6'd0; op4 = 6'd0; funct4 = 6'd0; ready4 = 1'b0;

    // Reset state.
    #12;
    check("reset_outputs", all_outs(), 32'd0);
    check("reset_retired", retired, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_fetch("fetch_after_reset");

    // Directed sequence.
    run_instr(OP_LW, 6'd0, 2, 2);
    run_instr(OP_R, 6'h20, 0, 0);
    run_instr(OP_SW, 6'd0, 0, 0);
    check("retired_after_three", retired, 32'd3);
    run_instr(OP_BEQ, 6'd0, 1, 0);
    run_instr(OP_BNE, 6'd0, 0, 0);
    run_instr(OP_JAL, 6'd0, 0, 0);
    run_instr(OP_R, 6'b001000, 0, 0);
    run_instr(6'b111111, 6'd0, 1, 0);
    run_instr(OP_ADDI, 6'd0, 0, 0);
    run_instr(OP_SLTI, 6'd0, 3, 0);
    run_instr(OP_XORI, 6'd0, 0, 0);
    run_instr(OP_J, 6'd0, 0, 0);
    run_instr(OP_SW, 6'd0, 2, 3);

    // Random instruction stream with random wait states.
    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 12);
      if (k >= 11) begin
        o = bad_ops[$urandom_range(0, 4)];
        f = 6'($urandom_range(0, 63));
      end else begin
        o = lop[k];
        f = 6'($urandom_range(0, 63));
        if (k == 3) f = 6'b001000;
        else if (f == 6'b001000) f = 6'h20;
      end
      run_instr(o, f, $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // Reset asserted while a store is waiting in MEM_WR.
    op = OP_SW; funct = 6'd0;
    mem_ready = 1'b1;
    @(negedge clk); @(posedge clk); #1;
    mem_ready = 1'b0;
    @(negedge clk); @(posedge clk); #1;
    @(negedge clk); @(posedge clk); #1;
    @(negedge clk);
    check("store_before_reset", {31'd0, mem_write && i_or_d}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("outputs_in_reset", all_outs(), 32'd0);
    check("retired_in_reset", retired, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_retired = 32'd0;
    wait_fetch("fetch_after_abort");
    run_instr(OP_J, 6'd0, 0, 0);

    // Narrow counter, mem_ready ignored: 17 instructions wrap to 1.
    @(posedge clk); #1;
    rst4_n = 1'b1;
    for (int i = 0; i < 17; i++) begin
      k = $urandom_range(0, 10);
      o = lop[k];
      f = (k == 3) ? 6'b001000 : 6'h22;
      op4 = o; funct4 = f;
      @(negedge clk);
      if (i == 0) begin
        for (int g = 0; g < 4 && !mr4; g++) @(negedge clk);
      end
      len = 1;
      while (!done4 && len < 16) begin
        @(negedge clk);
        len++;
      end
      @(posedge clk); #1;
      check("narrow_length", len, exp_len(cls(o, f), 0, 0));
      check("narrow_retired", {28'd0, retired4}, (i + 1) % 16);
    end
    check("narrow_wrap", {28'd0, retired4}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
